rom_scan_ctrl: RTL and testbench

ROM_SCAN_CTRL -- requirements
Module: rom_scan_ctrl

---
 rtl/rom_scan_pkg.sv | 37 +++
 rtl/rom_scan_fifo2.sv | 75 +++++++
 rtl/rom_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_rom_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_scan_pkg.sv
// rom_scan_pkg
//   Shared constants, FSM state type and the JPEG zigzag table for the
//   ROM scan controller. The helper scan_addr() maps a scan sequence
//   number k to a ROM address for either scan order.
package rom_scan_pkg;

  localparam int ROM_DEPTH = 64;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ZZ_TABLE[k] = natural (raster) address of the k-th coefficient in
  // JPEG zigzag order.
  localparam logic [ADDR_W-1:0] ZZ_TABLE [ROM_DEPTH] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [ADDR_W-1:0] scan_addr(input logic zz,
                                                  input logic [ADDR_W-1:0] k);
    return zz ? ZZ_TABLE[k] : k;
  endfunction

endpackage

// File: rtl/rom_scan_fifo2.sv
// rom_scan_fifo2
//   Two-entry data/index buffer. The head entry is a register and drives
//   the streaming outputs directly, so output data is always registered.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     push, push_data,    write one {data, idx} entry
//     push_idx
//     pop                 remove the head entry
//     head_data, head_idx current head entry (valid when count != 0)
//     count               number of stored entries (0..2)
module rom_scan_fifo2
  import rom_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_idx,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_idx,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] tail_data;
  logic [ADDR_W-1:0] tail_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_data <= '0;
      head_idx  <= '0;
      tail_data <= '0;
      tail_idx  <= '0;
      count     <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data;
            head_idx  <= push_idx;
            count     <= 2'd1;
          end else if (count == 2'd1) begin
            tail_data <= push_data;
            tail_idx  <= push_idx;
            count     <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            count     <= 2'd1;
          end else if (count == 2'd1) begin
            count <= 2'd0;
          end
        end
        2'b11: begin
          // Simultaneous write and read keeps occupancy unchanged.
          if (count == 2'd2) begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            tail_data <= push_data;
            tail_idx  <= push_idx;
          end else begin
            head_data <= push_data;
            head_idx  <= push_idx;
            count     <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl
//   Scans all 64 bytes of a registered-read ROM in raster or JPEG zigzag
//   order and streams them out with a valid/ready handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing ROM addresses k = 0..63
//   ST_DRAIN | all addresses issued, buffer still holds beats
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     start, zigzag            begin a scan / scan order (sampled in IDLE)
//     rom_a, rom_d             ROM address out, ROM data in (1-cycle read)
//     out_data, out_idx,       streamed byte, its sequence number k,
//     out_last, out_valid      last-beat flag, valid
//     out_ready                consumer accept
//     busy, done               scan in progress / completion pulse
module rom_scan_ctrl
  import rom_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              zigzag,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_d,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] issue_k;
  logic [ADDR_W-1:0] flight_k;
  logic              zz_mode;
  logic              in_flight;
  logic              issue;
  logic              done_n;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occ_after;

  assign pop       = out_valid & out_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign out_last  = out_valid && (out_idx == LAST_K);
  assign busy      = (state != ST_IDLE);
  assign rom_a     = scan_addr(zz_mode, issue_k);

  // Occupancy the buffer will have once this cycle's read lands and this
  // cycle's pop leaves; counting the pop lets issue continue every cycle
  // while the consumer keeps up, yet a stalled consumer never overflows.
  assign occ_after = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    issue   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_RUN;
      end
      ST_RUN: begin
        issue = (occ_after < 3'd2);
        if (issue && (issue_k == LAST_K)) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_k   <= '0;
      flight_k  <= '0;
      zz_mode   <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) flight_k <= issue_k;
      if ((state == ST_IDLE) && start) begin
        issue_k <= '0;
        zz_mode <= zigzag;
      end else if (issue && (issue_k != LAST_K)) begin
        issue_k <= issue_k + 1'b1;
      end
    end
  end

  rom_scan_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (rom_d),
    .push_idx  (flight_k),
    .pop       (pop),
    .head_data (out_data),
    .head_idx  (out_idx),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_rom_scan_ctrl.sv
module tb_rom_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, zigzag, out_ready;
  logic [5:0] rom_a, out_idx;
  logic [7:0] rom_d, out_data;
  logic       out_valid, out_last, busy, done;

  always #5 clk = ~clk;

  rom_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .zigzag    (zigzag),
    .rom_a     (rom_a),
    .rom_d     (rom_d),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  logic [7:0] rom_mem [64];
  int zz_ref [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  always @(posedge clk) rom_d <= rom_mem[rom_a];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         zz;
    int         mode;
    logic [7:0] d0, d1, d2, d3, dlast;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] cap_data [64];
  int         beats, first_valid, done_cycle;

  // Called just after the edge that accepted start; returns on the
  // falling edge of the cycle in which done is seen.
  task automatic collect(input bit zz, input int mode, input bit pulse_mid);
    int         c = 1;
    bit         toggle = 1'b1;
    int         stall_left = 0;
    bit         stalled = 1'b0;
    bit         prev_stall = 1'b0;
    bit         finished = 1'b0;
    bit         pulsing = 1'b0;
    bit         pulse_done = 1'b0;
    logic [7:0] pd = '0;
    logic [5:0] pi = '0;
    logic       pl = 1'b0;
    int         addr;
    beats = 0; first_valid = 0; done_cycle = 0;
    while (!finished && c < 400) begin
      @(negedge clk);
      if (c == 1) chk("busy_after_start", int'(busy), 1);
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(pd));
        chk("stall_idx", int'(out_idx), int'(pi));
        chk("stall_last", int'(out_last), int'(pl));
      end
      if (out_valid && first_valid == 0) first_valid = c;
      if (done) begin
        done_cycle = c;
        finished = 1'b1;
        chk("beats_at_done", beats, 64);
        chk("busy_at_done", int'(busy), 0);
      end else if (out_valid && out_ready) begin
        if (beats < 64) begin
          addr = zz ? zz_ref[beats] : beats;
          chk("beat_data", int'(out_data), int'(rom_mem[addr]));
          chk("beat_idx", int'(out_idx), beats);
          chk("beat_last", int'(out_last), (beats == 63) ? 1 : 0);
          cap_data[beats] = out_data;
        end
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_idx; pl = out_last;
      if (!finished) begin
        @(posedge clk); #1;
        c++;
        if (pulsing) begin
          start = 1'b0; zigzag = 1'b0; pulsing = 1'b0;
        end
        if (pulse_mid && !pulse_done && beats >= 20) begin
          start = 1'b1; zigzag = 1'b1; pulsing = 1'b1; pulse_done = 1'b1;
        end
        if (mode == 1) begin
          toggle = ~toggle;
          if (!stalled && out_valid && out_idx == 6'd5) begin
            stall_left = 10; stalled = 1'b1;
          end
          if (stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
          end else begin
            out_ready = toggle;
          end
        end
      end
    end
    chk("scan_done_seen", int'(finished), 1);
  endtask

  task automatic do_scan(input bit zz, input int mode);
    @(posedge clk); #1;
    start = 1'b1; zigzag = zz; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; zigzag = ~zz;
    collect(zz, mode, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_idle_after", int'(busy), 0);
  endtask

  initial begin
    bit found;
    for (int a = 0; a < 64; a++) rom_mem[a] = 8'(a * 5 + 3);
    rom_mem[0] = 8'hFF; rom_mem[1] = 8'h80; rom_mem[2] = 8'h6C; rom_mem[3] = 8'h5D;
    rom_mem[4] = 8'h4F; rom_mem[5] = 8'h4C; rom_mem[6] = 8'h47; rom_mem[7] = 8'h3C;
    rom_mem[8] = 8'h80; rom_mem[16] = 8'h6C; rom_mem[63] = 8'h19;

    vecs[0] = '{zz: 1'b0, mode: 0, d0: 8'hFF, d1: 8'h80, d2: 8'h6C, d3: 8'h5D, dlast: 8'h19};
    vecs[1] = '{zz: 1'b1, mode: 0, d0: 8'hFF, d1: 8'h80, d2: 8'h80, d3: 8'h6C, dlast: 8'h19};
    vecs[2] = '{zz: 1'b0, mode: 1, d0: 8'hFF, d1: 8'h80, d2: 8'h6C, d3: 8'h5D, dlast: 8'h19};
    vecs[3] = '{zz: 1'b1, mode: 1, d0: 8'hFF, d1: 8'h80, d2: 8'h80, d3: 8'h6C, dlast: 8'h19};

    rst = 1'b1; start = 1'b0; zigzag = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rom_a", int'(rom_a), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    for (int i = 0; i < 4; i++) begin
      do_scan(vecs[i].zz, vecs[i].mode);
      chk("vec_d0", int'(cap_data[0]), int'(vecs[i].d0));
      chk("vec_d1", int'(cap_data[1]), int'(vecs[i].d1));
      chk("vec_d2", int'(cap_data[2]), int'(vecs[i].d2));
      chk("vec_d3", int'(cap_data[3]), int'(vecs[i].d3));
      chk("vec_dlast", int'(cap_data[63]), int'(vecs[i].dlast));
      chk("vec_first_valid_cycle", first_valid, 3);
      if (vecs[i].mode == 0) chk("vec_done_cycle", done_cycle, 67);
    end

    // start held high: the second scan starts on the done cycle; a
    // mid-scan start pulse (with zigzag high) is ignored.
    @(posedge clk); #1;
    start = 1'b1; zigzag = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    collect(1'b0, 0, 1'b0);
    chk("restart_first_done_cycle", done_cycle, 67);
    @(posedge clk); #1;
    start = 1'b0;
    collect(1'b0, 0, 1'b1);
    chk("restart_first_valid", first_valid, 3);
    chk("restart_done_cycle", done_cycle, 67);
    chk("restart_d0", int'(cap_data[0]), 8'hFF);
    @(negedge clk);
    chk("restart_no_third", int'(busy), 0);

    // reset mid-scan, together with start
    @(posedge clk); #1;
    start = 1'b1; zigzag = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 6'd30) found = 1'b1;
    end
    chk("reached_k30", int'(found), 1);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_rom_a", int'(rom_a), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_out_idx", int'(out_idx), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_last", int'(out_last), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      chk("abort_stays_idle", int'(busy), 0);
    end
    do_scan(1'b0, 0);
    chk("after_abort_d0", int'(cap_data[0]), 8'hFF);
    chk("after_abort_first_valid", first_valid, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
